clock_gen: RTL and testbench

Programmable clock divider. It derives a divided clock `clk` from the reference clock `ref_clk`, using a runtime-loadable integer ratio. Even ratios give exactly 50% duty; odd ratios also give 50% duty by using both `ref_clk` edges. The block feeds downstream logic that counts or samples on the divided clock. It also provides a rising-edge strobe in the `ref_clk` domain and an activity status.

---
 rtl/clock_gen.sv | 94 +++++++++
 tb/tb_clock_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gen.sv
// Programmable divider producing a 50%-duty clock from ref_clk for any ratio,
// with a ref_clk-domain rising-edge strobe and a running status flag.
module clock_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             ref_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             div_load,
    output logic             clk,
    output logic             clk_rise,
    output logic             active
);

    localparam logic [DIV_W-1:0] DEF_RATIO = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [DIV_W-1:0] cnt_reg;
    logic [DIV_W-1:0] ratio_reg;
    logic [DIV_W-1:0] pend_reg;
    logic             active_reg;
    logic             rise_reg;
    logic             pos_reg;
    logic             neg_reg;
    logic             gate_reg;

    logic [DIV_W-1:0] pend_next;
    logic [DIV_W-1:0] eff_n;
    logic [DIV_W-1:0] eff_pend;
    logic [DIV_W-1:0] cnt_inc;
    logic             boundary;
    logic             odd_mode;

    // A zero ratio behaves exactly like a ratio of one.
    function automatic logic [DIV_W-1:0] legal_ratio(input logic [DIV_W-1:0] n);
        return (n == '0) ? ONE : n;
    endfunction

    // Posedge half of the waveform; ratio 1 is produced by the gated path instead.
    function automatic logic high_term(input logic [DIV_W-1:0] c, input logic [DIV_W-1:0] n);
        return (n != ONE) && (c < (n >> 1));
    endfunction

    assign pend_next = div_load ? div_ratio : pend_reg;
    assign eff_n     = legal_ratio(ratio_reg);
    assign eff_pend  = legal_ratio(pend_next);
    assign cnt_inc   = cnt_reg + ONE;
    assign boundary  = !active_reg || (cnt_reg == eff_n - ONE);
    assign odd_mode  = eff_n[0] && (eff_n != ONE);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            ratio_reg  <= DEF_RATIO;
            pend_reg   <= DEF_RATIO;
            active_reg <= 1'b0;
            rise_reg   <= 1'b0;
            pos_reg    <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            if (boundary) begin
                // New periods (and restarts from idle) pick up the latest pending ratio.
                ratio_reg  <= pend_next;
                cnt_reg    <= '0;
                active_reg <= en;
                rise_reg   <= en;
                pos_reg    <= en && high_term('0, eff_pend);
            end else begin
                cnt_reg  <= cnt_inc;
                rise_reg <= 1'b0;
                pos_reg  <= high_term(cnt_inc, eff_n);
            end
        end
    end

    // Falling-edge copies: odd-ratio half-cycle extension and the ratio-1 gate,
    // which predicts whether the coming posedge opens a ratio-1 period.
    always_ff @(negedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_reg  <= 1'b0;
            gate_reg <= 1'b0;
        end else begin
            neg_reg  <= pos_reg && odd_mode;
            gate_reg <= en && boundary && (eff_pend == ONE);
        end
    end

    assign clk      = pos_reg | neg_reg | (ref_clk & gate_reg);
    assign clk_rise = rise_reg;
    assign active   = active_reg;

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: a half-cycle level model of the divided clock plus
// literal period/duty measurements on the produced clock.
`timescale 1ps/1ps
module tb_clock_gen;

    logic       ref_clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_ratio;
    logic       div_load;
    logic       clk;
    logic       clk_rise;
    logic       active;

    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    clock_gen #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
        .ref_clk  (ref_clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_ratio(div_ratio),
        .div_load (div_load),
        .clk      (clk),
        .clk_rise (clk_rise),
        .active   (active)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: k = ref_clk cycles since the current period began; within a period of
    // N the clock is high for the first N of its 2N half-cycles.
    bit m_run;
    int m_k;
    int m_n;
    int m_pend;

    function automatic int legal(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    initial begin
        m_run = 0; m_k = 0; m_n = 2; m_pend = 2;
        while (!done) begin
            @(posedge ref_clk);
            if (!rst_n) begin
                m_run = 0; m_k = 0; m_n = 2; m_pend = 2;
            end else begin
                if (div_load) m_pend = legal(int'(div_ratio));
                if (!m_run) begin
                    m_n = m_pend;
                    if (en) begin m_run = 1; m_k = 0; end
                end else if (m_k + 1 == m_n) begin
                    m_n = m_pend;
                    m_k = 0;
                    m_run = en;
                end else begin
                    m_k++;
                end
            end
            #2;
            chk("clk_pos", clk, (m_run && (2 * m_k < m_n)) ? 1 : 0);
            chk("clk_rise", clk_rise, (m_run && m_k == 0) ? 1 : 0);
            chk("active", active, m_run ? 1 : 0);
            @(negedge ref_clk);
            #2;
            chk("clk_neg", clk, (m_run && (2 * m_k + 1 < m_n)) ? 1 : 0);
        end
    end

    // Waveform measurements on the divided clock.
    longint   last_rise_t = 0;
    longint   period_t    = 0;
    longint   high_t      = 0;
    longint   last_fall_t = 0;
    logic [4:0] cnt5 = '0;

    always @(posedge clk) begin
        period_t    = $time - last_rise_t;
        last_rise_t = $time;
        cnt5        = cnt5 + 5'd1;
    end

    always @(negedge clk) begin
        high_t      = $time - last_rise_t;
        last_fall_t = $time;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic load(input int n);
        div_ratio = 8'(n);
        div_load  = 1'b1;
        cycles(1);
        div_load  = 1'b0;
    endtask

    task automatic wait_k(input int k);
        int budget;
        budget = 400;
        while (!(m_run && m_k == k) && budget > 0) begin
            cycles(1);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_k: got timeout expected counter %0d", k);
        end
    endtask

    task automatic measure(input string name, input longint per, input longint hi);
        chk({name, "_period"}, period_t, per);
        chk({name, "_high"}, high_t, hi);
    endtask

    longint t_edge;

    initial begin
        rst_n = 1'b0; en = 1'b0; div_ratio = '0; div_load = 1'b0;
        cycles(3);
        chk("reset_clk", clk, 0);
        chk("reset_active", active, 0);
        chk("reset_rise", clk_rise, 0);

        // Default ratio 2.
        rst_n = 1'b1; en = 1'b1;
        cycles(12);
        measure("n2", 20, 10);
        cnt5 = '0;
        #100;
        chk("n2_count100", cnt5, 5);
        cycles(1);

        // Ratio 4 loaded mid-period.
        load(4);
        cycles(12);
        measure("n4", 40, 20);

        load(3);
        cycles(12);
        measure("n3", 30, 15);
        chk("n3_fall_on_negedge", last_fall_t % 10, 0);

        load(1);
        cycles(12);
        measure("n1", 10, 5);
        load(0);
        cycles(12);
        measure("n0", 10, 5);

        // Stop at counter 1, then restart.
        load(4);
        cycles(12);
        wait_k(1);
        en = 1'b0;
        cycles(8);
        chk("stop_active", active, 0);
        chk("stop_clk", clk, 0);
        chk("stop_last_high", high_t, 20);
        en = 1'b1;
        @(posedge ref_clk);
        t_edge = $time;
        #1;
        chk("restart_clk", clk, 1);
        chk("restart_rise_time", last_rise_t, t_edge);

        // Asynchronous reset while clk is high.
        @(negedge ref_clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_clk", clk, 0);
        chk("arst_active", active, 0);
        chk("arst_rise", clk_rise, 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(12);
        measure("post_reset", 20, 10);

        // Two loads in one period: the last one wins.
        load(4);
        cycles(12);
        wait_k(0);
        load(6);
        load(8);
        cycles(30);
        measure("n8", 80, 40);

        // Randomized enables and ratio loads, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            div_load  = ($urandom_range(0, 7) == 0);
            div_ratio = 8'($urandom_range(0, 9));
            cycles(1);
        end
        en = 1'b1; div_load = 1'b0;
        cycles(4);

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
